// File: rtl/async_step_issuer.sv
// Batches per-cycle commit counts into one-cycle step pulses for the async
// controller, and stops issuing once the controller reports a sticky halt.
module async_step_issuer #(
  parameter int STEP_WIDTH      = 8,
  parameter int COMMIT_WIDTH    = 4,
  parameter int BATCH_THRESHOLD = 64,
  parameter int FLUSH_TIMEOUT   = 1000,
  parameter int TIMER_WIDTH     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    commit_valid,
  input  logic [COMMIT_WIDTH-1:0] commit_num,
  input  logic                    flush_req,
  input  logic                    simv_result,
  output logic [STEP_WIDTH-1:0]   step,
  output logic                    halted,
  output logic [63:0]             total_steps,
  output logic [63:0]             dropped_steps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [STEP_WIDTH-1:0]  THRESH  = STEP_WIDTH'(BATCH_THRESHOLD);
  localparam logic [TIMER_WIDTH-1:0] TO_LAST = TIMER_WIDTH'(FLUSH_TIMEOUT - 1);

  function automatic logic [63:0] widen(input logic [STEP_WIDTH-1:0] v);
    return {{(64 - STEP_WIDTH){1'b0}}, v};
  endfunction

  state_t                  state_q, state_d;
  logic [STEP_WIDTH-1:0]   acc_q, acc_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic [STEP_WIDTH-1:0]   step_q, step_d;
  logic [63:0]             total_q, total_d;
  logic [63:0]             dropped_q, dropped_d;
  logic                    halted_q, halted_d;

  logic [STEP_WIDTH-1:0]   in_w;
  logic [STEP_WIDTH-1:0]   sum_w;
  logic                    emit_w;

  // Parameter bounds keep acc + in inside STEP_WIDTH bits.
  assign in_w  = commit_valid ? {{(STEP_WIDTH - COMMIT_WIDTH){1'b0}}, commit_num}
                              : '0;
  assign sum_w = acc_q + in_w;

  always_comb begin
    emit_w = 1'b0;
    if (state_q != HALT && !simv_result && sum_w != '0) begin
      emit_w = (sum_w >= THRESH) || flush_req ||
               (state_q == ACCUM && timer_q == TO_LAST);
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    timer_d   = timer_q;
    step_d    = '0;
    total_d   = total_q;
    dropped_d = dropped_q;
    halted_d  = halted_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        // Halt takes priority over any emission in the same cycle.
        if (simv_result) begin
          dropped_d = dropped_q + widen(sum_w);
          acc_d     = '0;
          timer_d   = '0;
          state_d   = HALT;
          halted_d  = 1'b1;
        end else if (emit_w) begin
          step_d  = sum_w;
          acc_d   = '0;
          timer_d = '0;
          total_d = total_q + widen(sum_w);
          state_d = IDLE;
        end else begin
          acc_d   = sum_w;
          state_d = (sum_w != '0) ? ACCUM : IDLE;
          timer_d = (state_q == ACCUM) ? timer_q + 1'b1 : '0;
        end
      end
      HALT: begin
        dropped_d = dropped_q + widen(in_w);
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      timer_q   <= '0;
      step_q    <= '0;
      total_q   <= '0;
      dropped_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      timer_q   <= timer_d;
      step_q    <= step_d;
      total_q   <= total_d;
      dropped_q <= dropped_d;
      halted_q  <= halted_d;
    end
  end

  assign step          = step_q;
  assign halted        = halted_q;
  assign total_steps   = total_q;
  assign dropped_steps = dropped_q;

endmodule

// File: tb/tb_async_step_issuer.sv
// Directed bench for async_step_issuer: expected step pulses are queued with
// their due cycle when stimulus is driven and matched as the DUT emits them.
module tb_async_step_issuer;

  localparam int FT = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [3:0]  commit_num;
  logic        flush_req;
  logic        simv_result;
  logic [7:0]  step;
  logic        halted;
  logic [63:0] total_steps;
  logic [63:0] dropped_steps;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  async_step_issuer dut (
    .clock         (clock),
    .reset         (reset),
    .commit_valid  (commit_valid),
    .commit_num    (commit_num),
    .flush_req     (flush_req),
    .simv_result   (simv_result),
    .step          (step),
    .halted        (halted),
    .total_steps   (total_steps),
    .dropped_steps (dropped_steps)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, then match any step pulse against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (step != 8'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_step", 64'(step), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("step_val", 64'(step), 64'(e.val));
        chk("step_cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      chk("missing_step", 64'(step), 64'(sb[0].val));
      void'(sb.pop_front());
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] n, input logic f, input logic r);
    commit_valid = v;
    commit_num   = n;
    flush_req    = f;
    simv_result  = r;
  endtask

  task automatic expect_step(input logic [7:0] val, input int lat);
    exp_t e;
    e.val = val;
    e.due = cyc + lat;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_step", 64'(step), 64'd0);
    chk("rst_total", total_steps, 64'd0);
    chk("rst_dropped", dropped_steps, 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    reset = 1'b0;
    tick();

    // T1: 16 x 4 reaches the threshold exactly
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'd4, 1'b0, 1'b0);
      if (i == 15) expect_step(8'd64, 1);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t1_total", total_steps, 64'd64);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // T2: acc 62 plus 15 is emitted whole as 77
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd15, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd15, 1'b0, 1'b0);
    expect_step(8'd77, 1);
    tick();
    drive(1'b0, 4'd9, 1'b0, 1'b0);
    tick();
    tick();
    chk("t2_total", total_steps, 64'd141);

    // T3: a lone commit of 3 flushes on timeout
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    expect_step(8'd3, 1 + FT);
    tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < FT + 5; i++) tick();
    chk("t3_total", total_steps, 64'd144);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // T4: flush with pending count, then flush with nothing pending
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd2, 1'b1, 1'b0);
    expect_step(8'd7, 1);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    chk("t4_total", total_steps, 64'd151);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // T5: halt beats a threshold emission in the same cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd15, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'd10, 1'b0, 1'b1);
    tick();
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_dropped", dropped_steps, 64'd70);
    chk("t5_total", total_steps, 64'd151);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd2, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    tick();
    chk("t5_dropped2", dropped_steps, 64'd80);
    chk("t5_halted2", 64'(halted), 64'd1);
    chk("t5_total2", total_steps, 64'd151);

    // T6: reset clears halt, then a pending batch of 30 is discarded by reset
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_halt_cleared", 64'(halted), 64'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'd15, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_step", 64'(step), 64'd0);
    chk("t6_total", total_steps, 64'd0);
    chk("t6_dropped", dropped_steps, 64'd0);
    chk("t6_halted", 64'(halted), 64'd0);
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 4'd1, 1'b0, 1'b0);
      if (i == 63) expect_step(8'd64, 1);
      tick();
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t6_total2", total_steps, 64'd64);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
